// File: rtl/mem_access_unit.sv
// Single-port data-memory access unit: one outstanding CPU load/store, optional strobe stretching.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap odd byte addresses without touching memory.
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] addres,
  output logic [31:0] memWdata,
  output logic        memW,
  output logic        memR,
  input  logic [31:0] memRdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept;
  logic        last_access;
  logic        mis;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign mis = req_addr[0];
`else
  assign mis = 1'b0;
`endif

  assign accept      = (state_q == IDLE) && req_valid;
  assign last_access = (state_q == ACCESS) && (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; counter is only loaded in IDLE and never wraps below 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = mis ? RESP : ACCESS;
          cnt_d   = mis ? 4'd0 : WAIT_INIT;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Datapath next values: request latched on accept, read data captured on last ACCESS cycle
  always_comb begin
    req_d   = req_q;
    rdata_d = rdata_q;
    if (accept && !mis) begin
      req_d.we    = req_we;
      req_d.addr  = req_addr;
      req_d.wdata = req_wdata;
    end
    if (accept && mis) rdata_d = 32'd0;
    if (last_access)   rdata_d = req_q.we ? 32'd0 : memRdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      rdata_q <= 32'd0;
    end else begin
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_comb begin
    err_d = err_q;
    if (accept) err_d = mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Output logic; strobes are pure decodes of state so reset kills them immediately
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    memR       = (state_q == ACCESS) && !req_q.we;
    memW       = last_access && req_q.we;
  end

  assign addres     = req_q.addr;
  assign memWdata   = req_q.wdata;
  assign resp_rdata = rdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, meaning extra cycles the memory strobe is held before completion (0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU-side request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  16  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 resp_valid  output  1  response present.
REQ-010 resp_ready  input  1  CPU consumes the response.
REQ-011 resp_rdata  output  32  load data; 0 for stores.
REQ-012 resp_err  output  1  misaligned-access flag.
REQ-013 addres  output  16  data-memory address.
REQ-014 memWdata  output  32  data-memory write data.
REQ-015 memW  output  1  data-memory write strobe.
REQ-016 memR  output  1  data-memory read enable.
REQ-017 memRdata  input  32  data-memory read data, combinational from addres/memR.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on req_valid=1 at a rising edge, latch req_we/req_addr/req_wdata, load the wait counter with WAIT_CYCLES, go to ACCESS.
REQ-020 ACCESS: addres/memWdata SHALL be driven from the latched values; memR=1 every ACCESS cycle of a load; memW=1 only in the final ACCESS cycle of a store (exactly one write per store).
REQ-021 ACCESS: the counter decrements each cycle; when it is 0, capture memRdata into resp_rdata (load) or load 0 (store), then go to RESP.
REQ-022 Latency: request accepted at edge N -> resp_valid=1 after edge N+WAIT_CYCLES+1.
REQ-023 RESP: resp_valid=1 with stable resp_rdata/resp_err until resp_ready=1 at an edge, then go to IDLE; a new request can be accepted no earlier than the following edge (no back-to-back bypass).
REQ-024 resp_ready while not in RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored (not queued).
REQ-025 Outside ACCESS: memW=0, memR=0; addres/memWdata hold their last values.
REQ-026 Counter width 4 bits; no wrap-around: the counter is only loaded in IDLE and stops at 0.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, memW=0, memR=0, resp_valid=0, resp_err=0, resp_rdata=0, addres=0, memWdata=0; req_ready=1 once in IDLE.
REQ-028 Reset asserted during ACCESS SHALL abort the access; no memW pulse SHALL occur after rst_n falls.

Configuration
REQ-029 Macro MEM_ACCESS_MISALIGN_TRAP_EN: when defined, a request with req_addr[0]=1 SHALL skip ACCESS, go directly to RESP on the next edge with resp_err=1 and resp_rdata=0, and never assert memW/memR.
REQ-030 When MEM_ACCESS_MISALIGN_TRAP_EN is undefined, resp_err SHALL be constant 0 and req_addr[0] SHALL be passed to addres unchanged.

Verification
REQ-031 WAIT_CYCLES=0: store addr 0x0010 data 0x0000ABCD, resp_ready=1 -> one memW pulse with addres=0x0010, resp_valid after 1 cycle, resp_rdata=0.
REQ-032 WAIT_CYCLES=0: load addr 0x0010 after REQ-031 store -> memR=1 for one cycle, resp_rdata=0x0000ABCD.
REQ-033 WAIT_CYCLES=3: load -> memR high 4 cycles, resp_valid asserted on edge N+4; store -> memW high only in the 4th cycle.
REQ-034 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, second req_valid ignored.
REQ-035 rst_n pulsed low mid-ACCESS of a store with WAIT_CYCLES=3 -> no memW, all outputs at reset values, req_ready=1.
REQ-036 MEM_ACCESS_MISALIGN_TRAP_EN defined, store to 0x0011 -> memW never asserted, resp_err=1, resp_valid after 1 cycle; undefined -> normal store with addres=0x0011.
